ps_frame_sequencer: RTL and testbench

PS_FRAME_SEQUENCER -- requirements
Module: ps_frame_sequencer

---
 rtl/ps_seq_pkg.sv | 25 ++
 rtl/ps_pixel_counter.sv | 40 ++++
 rtl/ps_frame_sequencer.sv | 177 +++++++++++++++++
 tb/tb_ps_frame_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ps_seq_pkg.sv
// rtl/ps_seq_pkg.sv - shared types and widths for the frame sequencer
//
// Contents:
//   PIX_CNT_W    - width of the per-frame pixel counter
//   seq_state_t  - sequencer state encoding (IDLE/FLUSH/WAIT_SOF/RUN)
//   frame_pixels - pixels per frame for a given geometry

package ps_seq_pkg;

  // Wide enough for 640x480 (307200) with headroom up to 2^19-1.
  localparam int unsigned PIX_CNT_W = 19;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_WAIT_SOF = 2'd2,
    ST_RUN      = 2'd3
  } seq_state_t;

  function automatic int unsigned frame_pixels(input int unsigned width,
                                               input int unsigned height);
    return width * height;
  endfunction

endpackage

// File: rtl/ps_pixel_counter.sv
// rtl/ps_pixel_counter.sv - per-frame pixel counter with full-frame compare
//
// Parameters:
//   FRAME_PIXELS - pixel count of one complete frame
// Ports:
//   i_clk   - clock, rising edge
//   i_rstn  - asynchronous active-low reset
//   i_clr   - restart the count; the new value is i_inc (0 or 1)
//   i_inc   - count one pixel
//   o_full  - count equals FRAME_PIXELS

module ps_pixel_counter
  import ps_seq_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = 307200
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_full
);

  logic [PIX_CNT_W-1:0] count;

  // A restart that coincides with a pixel starts the new frame at 1,
  // so the pixel accepted on the SOF cycle belongs to the new frame.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count <= '0;
    end else if (i_clr) begin
      count <= {{(PIX_CNT_W-1){1'b0}}, i_inc};
    end else if (i_inc) begin
      count <= count + 1'b1;
    end
  end

  assign o_full = (count == PIX_CNT_W'(FRAME_PIXELS));

endmodule

// File: rtl/ps_frame_sequencer.sv
// rtl/ps_frame_sequencer.sv - frame sequencer FSM for the processing core
//
// Build option: define FRAME_SEQ_WATCHDOG_EN to include the pixel-starvation
// watchdog; otherwise o_err_timeout is tied low and no timer is built.
//
// Ports:
//   i_clk          - clock, rising edge
//   i_rstn         - asynchronous active-low reset
//   i_enable       - software run request (level)
//   i_sof          - start-of-frame pulse, synchronous to i_clk
//   i_in_pix       - one pixel accepted by the core this cycle
//   i_err_clr      - clear sticky error flags (a coincident set wins)
//   o_flush        - flush to the processing core (IDLE and FLUSH)
//   o_run          - high in RUN only
//   o_state        - current state encoding
//   o_frame_cnt    - completed good frames, wraps at 16 bits
//   o_err_short    - sticky: SOF arrived before a full frame
//   o_err_overrun  - sticky: pixel arrived after a full frame without SOF
//   o_err_timeout  - sticky: watchdog expired in RUN

module ps_frame_sequencer
  import ps_seq_pkg::*;
#(
  parameter int unsigned IMG_WIDTH       = 640,
  parameter int unsigned IMG_HEIGHT      = 480,
  parameter int unsigned FLUSH_CYCLES    = 16,
  parameter int unsigned WATCHDOG_CYCLES = 65535
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_enable,
  input  logic        i_sof,
  input  logic        i_in_pix,
  input  logic        i_err_clr,
  output logic        o_flush,
  output logic        o_run,
  output logic [1:0]  o_state,
  output logic [15:0] o_frame_cnt,
  output logic        o_err_short,
  output logic        o_err_overrun,
  output logic        o_err_timeout
);

  localparam int unsigned FRAME_PIXELS = frame_pixels(IMG_WIDTH, IMG_HEIGHT);

  seq_state_t state;
  seq_state_t nxt;
  logic [7:0] flush_cnt;
  logic       flush_done;
  logic       pix_full;
  logic       pix_clr;
  logic       pix_inc;
  logic       stay_run;
  logic       set_short;
  logic       set_overrun;
  logic       set_timeout;
  logic       frame_inc;
  logic       wd_expire;

  assign flush_done = (flush_cnt == 8'(FLUSH_CYCLES - 1));
  assign stay_run   = (state == ST_RUN) && (nxt == ST_RUN);

  // The counter only advances while RUN continues; any exit from RUN, any
  // entry into RUN and any good-frame SOF restarts it.
  assign pix_inc = stay_run && i_in_pix;
  assign pix_clr = !stay_run || i_sof;

  ps_pixel_counter #(
    .FRAME_PIXELS(FRAME_PIXELS)
  ) u_pix_cnt (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_clr (pix_clr),
    .i_inc (pix_inc),
    .o_full(pix_full)
  );

  // Next-state decode. In RUN, disable beats SOF, SOF beats pixel, and the
  // SOF check always uses the count before this cycle's pixel.
  always_comb begin
    nxt         = state;
    set_short   = 1'b0;
    set_overrun = 1'b0;
    set_timeout = 1'b0;
    frame_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_enable) nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        // A flush always runs to completion; enable only picks the exit.
        if (flush_done) nxt = i_enable ? ST_WAIT_SOF : ST_IDLE;
      end
      ST_WAIT_SOF: begin
        if (!i_enable)  nxt = ST_FLUSH;
        else if (i_sof) nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!i_enable) begin
          nxt = ST_FLUSH;
        end else if (i_sof) begin
          if (pix_full) begin
            frame_inc = 1'b1;
          end else begin
            set_short = 1'b1;
            nxt       = ST_FLUSH;
          end
        end else if (i_in_pix && pix_full) begin
          set_overrun = 1'b1;
          nxt         = ST_FLUSH;
        end else if (wd_expire) begin
          set_timeout = 1'b1;
          nxt         = ST_FLUSH;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state         <= ST_IDLE;
      o_flush       <= 1'b1;
      o_run         <= 1'b0;
      flush_cnt     <= '0;
      o_frame_cnt   <= '0;
      o_err_short   <= 1'b0;
      o_err_overrun <= 1'b0;
    end else begin
      state   <= nxt;
      o_flush <= (nxt == ST_IDLE) || (nxt == ST_FLUSH);
      o_run   <= (nxt == ST_RUN);

      if (state != ST_FLUSH) flush_cnt <= '0;
      else                   flush_cnt <= flush_cnt + 8'd1;

      if (frame_inc) o_frame_cnt <= o_frame_cnt + 16'd1;

      o_err_short   <= set_short   || (o_err_short   && !i_err_clr);
      o_err_overrun <= set_overrun || (o_err_overrun && !i_err_clr);
    end
  end

  assign o_state = state;

`ifdef FRAME_SEQ_WATCHDOG_EN
  logic [31:0] wd_cnt;

  // Counts consecutive pixel-free RUN cycles; restarts on any pixel or any
  // state change so each RUN entry gets a full window.
  assign wd_expire = (state == ST_RUN) && !i_in_pix &&
                     (wd_cnt == 32'(WATCHDOG_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wd_cnt        <= '0;
      o_err_timeout <= 1'b0;
    end else begin
      if ((state != ST_RUN) || (nxt != state) || i_in_pix) wd_cnt <= '0;
      else                                                 wd_cnt <= wd_cnt + 32'd1;
      o_err_timeout <= set_timeout || (o_err_timeout && !i_err_clr);
    end
  end
`else
  assign wd_expire     = 1'b0;
  assign o_err_timeout = 1'b0;

  // Keeps WATCHDOG_CYCLES referenced so both builds share one parameter list.
  if (WATCHDOG_CYCLES == 0) begin : g_wd_param_ref
  end
`endif

  // set_timeout is constant low without the watchdog.
  logic unused_ok;
  assign unused_ok = set_timeout;

endmodule

// File: tb/tb_ps_frame_sequencer.sv
// tb/tb_ps_frame_sequencer.sv - directed self-checking bench for ps_frame_sequencer

module tb_ps_frame_sequencer;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic        sof;
  logic        in_pix;
  logic        err_clr;
  logic        flush;
  logic        run;
  logic [1:0]  state;
  logic [15:0] frame_cnt;
  logic        err_short;
  logic        err_overrun;
  logic        err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  ps_frame_sequencer #(
    .IMG_WIDTH      (8),
    .IMG_HEIGHT     (4),
    .FLUSH_CYCLES   (4),
    .WATCHDOG_CYCLES(20)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_enable     (enable),
    .i_sof        (sof),
    .i_in_pix     (in_pix),
    .i_err_clr    (err_clr),
    .o_flush      (flush),
    .o_run        (run),
    .o_state      (state),
    .o_frame_cnt  (frame_cnt),
    .o_err_short  (err_short),
    .o_err_overrun(err_overrun),
    .o_err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixels(input int n);
    in_pix = 1'b1;
    repeat (n) tick();
    in_pix = 1'b0;
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    rstn    = 1'b1;
    enable  = 1'b0;
    sof     = 1'b0;
    in_pix  = 1'b0;
    err_clr = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_flush", flush, 1);
    check("rst_run", run, 0);
    check("rst_frame", frame_cnt, 0);
    check("rst_flags", {err_short, err_overrun, err_timeout}, 0);
    tick();
    tick();
    rstn = 1'b1;

    // Startup: IDLE -> FLUSH for 4 cycles -> WAIT_SOF -> RUN
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("start_flush_state", state, 1);
      check("start_flush_out", flush, 1);
    end
    tick();
    check("wait_state", state, 2);
    check("wait_flush", flush, 0);
    pulse_sof();
    check("run_state", state, 3);
    check("run_out", run, 1);

    // Three good frames
    for (int f = 0; f < 3; f++) begin
      pixels(32);
      pulse_sof();
    end
    check("good_frames", frame_cnt, 3);
    check("good_state", state, 3);
    check("good_flags", {err_short, err_overrun, err_timeout}, 0);

    // Short frame
    pixels(31);
    pulse_sof();
    check("short_flag", err_short, 1);
    check("short_state", state, 1);
    check("short_flush", flush, 1);
    repeat (3) tick();
    check("short_flush_hold", state, 1);
    tick();
    check("short_to_wait", state, 2);
    pulse_clr();
    check("short_clr", err_short, 0);

    // Overrun, with a coincident clear that must lose to the set
    pulse_sof();
    check("ovr_run", state, 3);
    pixels(32);
    in_pix  = 1'b1;
    err_clr = 1'b1;
    tick();
    in_pix  = 1'b0;
    err_clr = 1'b0;
    check("ovr_flag_set_wins", err_overrun, 1);
    check("ovr_state", state, 1);
    check("ovr_frame", frame_cnt, 3);
    repeat (4) tick();
    check("ovr_to_wait", state, 2);
    pulse_clr();
    check("ovr_clr", err_overrun, 0);

    // SOF coincident with pixel 33: good frame, next count starts at 1
    pulse_sof();
    pixels(32);
    sof    = 1'b1;
    in_pix = 1'b1;
    tick();
    sof    = 1'b0;
    in_pix = 1'b0;
    check("coin_frame", frame_cnt, 4);
    check("coin_state", state, 3);
    pixels(31);
    pulse_sof();
    check("coin_next_frame", frame_cnt, 5);
    check("coin_no_short", err_short, 0);
    check("coin_still_run", state, 3);

    // Asynchronous reset mid-frame at count 17
    pixels(17);
    rstn = 1'b0;
    #1;
    check("mid_rst_state", state, 0);
    check("mid_rst_flush", flush, 1);
    check("mid_rst_run", run, 0);
    check("mid_rst_frame", frame_cnt, 0);
    tick();
    rstn = 1'b1;
    repeat (5) tick();
    check("rerun_wait", state, 2);
    pulse_sof();
    check("rerun_run", state, 3);

    // Enable drop in RUN: FLUSH for 4 cycles then IDLE
    enable = 1'b0;
    tick();
    check("dis_state", state, 1);
    check("dis_flush", flush, 1);
    check("dis_run", run, 0);
    repeat (3) tick();
    check("dis_flush_hold", state, 1);
    tick();
    check("dis_idle", state, 0);
    check("dis_idle_flush", flush, 1);

    // Pixel starvation in RUN
    enable = 1'b1;
    repeat (5) tick();
    pulse_sof();
    check("wd_run", state, 3);
    repeat (19) tick();
    check("wd_19_state", state, 3);
    check("wd_19_flag", err_timeout, 0);
    tick();
`ifdef FRAME_SEQ_WATCHDOG_EN
    check("wd_20_flag", err_timeout, 1);
    check("wd_20_state", state, 1);
`else
    check("wd_20_flag", err_timeout, 0);
    check("wd_20_state", state, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
